// File: rtl/uart_core_rx.sv
// UART receiver: 2-flop synchronizer, 8x oversampling tick chain, configurable frame decoder.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting; otherwise a single mid-bit sample is used.
module uart_core_rx #(
    parameter int CLK_FREQ       = 100,
    parameter int BAUD_DIV_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]                data_type,
    input  logic [1:0]                stop_type,
    input  logic                      check_en,
    input  logic [1:0]                check_type,
    input  logic                      rx,
    output logic [7:0]                data,
    output logic                      ack,
    output logic                      check_err,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int CLK_DIV = CLK_FREQ / 10;
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START,
        S_DATA0, S_DATA1, S_DATA2, S_DATA3, S_DATA4, S_DATA5, S_DATA6, S_DATA7,
        S_CHECK, S_STOP, S_WAIT
    } state_t;

    state_t                    state, state_next;
    logic                      rx_meta, rxs;
    logic [CNT_W-1:0]          clk_count;
    logic [BAUD_DIV_WIDTH-1:0] hns_count;
    logic [2:0]                sample_count;
    logic                      clk_wrap, tick, bit_end, decide, bit_now, cnt_clr;
    logic                      in_data, exp_chk, bit_val, chk_flag;
    logic [2:0]                data_idx, last_idx;
    logic [7:0]                sr;
    logic                      unused_cfg;

    // Only the first stop bit is validated, so the stop length never affects reception.
    assign unused_cfg = ^stop_type;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign clk_wrap = (clk_count == CNT_W'(CLK_DIV - 1));
    assign tick     = clk_wrap && (hns_count == baud_div);
    assign bit_end  = tick && (sample_count == 3'd7);
    assign last_idx = 3'd7 - {1'b0, data_type};

`ifdef UART_RX_MAJORITY_EN
    logic s3, s4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3 <= 1'b0;
            s4 <= 1'b0;
        end else if (tick) begin
            if (sample_count == 3'd3) s3 <= rxs;
            if (sample_count == 3'd4) s4 <= rxs;
        end
    end

    assign decide  = tick && (sample_count == 3'd5);
    assign bit_now = (s3 & s4) | (s3 & rxs) | (s4 & rxs);
`else
    assign decide  = tick && (sample_count == 3'd4);
    assign bit_now = rxs;
`endif

    // Clearing on entry as well as while resident keeps every bit period aligned to the start edge.
    assign cnt_clr = (state == S_IDLE) || (state == S_WAIT) ||
                     (state_next == S_IDLE) || (state_next == S_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_count    <= '0;
            hns_count    <= '0;
            sample_count <= '0;
        end else if (cnt_clr) begin
            clk_count    <= '0;
            hns_count    <= '0;
            sample_count <= '0;
        end else if (clk_wrap) begin
            clk_count <= '0;
            if (hns_count == baud_div) begin
                hns_count    <= '0;
                sample_count <= sample_count + 3'd1;
            end else begin
                hns_count <= hns_count + 1'b1;
            end
        end else begin
            clk_count <= clk_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        in_data    = 1'b0;
        data_idx   = '0;
        case (check_type)
            2'b00:   exp_chk = ~^sr;
            2'b01:   exp_chk = ^sr;
            2'b10:   exp_chk = 1'b1;
            default: exp_chk = 1'b0;
        endcase
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (!rxs) state_next = S_START;
            end
            S_START: begin
                if (decide && bit_now) state_next = S_IDLE;
                else if (bit_end)      state_next = S_DATA0;
            end
            S_DATA0, S_DATA1, S_DATA2, S_DATA3, S_DATA4, S_DATA5, S_DATA6, S_DATA7: begin
                in_data  = 1'b1;
                data_idx = 3'(state - S_DATA0);
                if (bit_end) begin
                    if (data_idx == last_idx) state_next = check_en ? S_CHECK : S_STOP;
                    else                      state_next = state_t'(state + 4'd1);
                end
            end
            S_CHECK: begin
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                if (decide) state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b0;
                if (rxs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            chk_flag  <= 1'b0;
            bit_val   <= 1'b0;
            data      <= '0;
            ack       <= 1'b0;
            check_err <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (state == S_IDLE) begin
                sr       <= '0;
                chk_flag <= 1'b0;
            end
            if (decide) bit_val <= bit_now;
            // Writing by index leaves the word right-justified with zeroed upper bits.
            if (in_data && bit_end) sr[data_idx] <= bit_val;
            if (state == S_CHECK && bit_end) chk_flag <= bit_val ^ exp_chk;
            if (state == S_STOP && decide) begin
                data      <= sr;
                check_err <= check_en & chk_flag;
                frame_err <= ~bit_now;
                ack       <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_core_rx.md
Name: uart_core_rx

Overview:
- Receive half of the UART core. Consumes the serial line driven by the TX core of a peer device.
- Uses the same oversampling clock scheme as the TX side: 8 samples per bit, with a baud divider derived from a 10 MHz reference.
- Supports runtime-configurable data bits, stop bits and check bit.
- Presents each received byte on a parallel port with a one-cycle ack pulse and error flags for the bus-side UART controller.

Parameters:
- CLK_FREQ, 100, main clock frequency in MHz; must be a multiple of 10.
- BAUD_DIV_WIDTH, 8, width of baud_div.

Ports:
- clk  input  1  main clock.
- rst_n  input  1  reset; asynchronous, active-low.
- baud_div  input  BAUD_DIV_WIDTH  equals 10M/8/baudrate-1.
- data_type  input  2  data bits: 00=8, 01=7, 10=6, 11=5.
- stop_type  input  2  stop bits: 00=1, 01=1.5, 10=2. Receiver validates only the first stop bit.
- check_en  input  1  check bit present.
- check_type  input  2  check bit type: 00=odd, 01=even, 10=mark, 11=space.
- rx  input  1  asynchronous serial line; idle high.
- data  output  8  received word, LSB-first assembly, right-justified, unused upper bits 0.
- ack  output  1  one-cycle pulse: data and flags are valid.
- check_err  output  1  check bit mismatch for the current word.
- frame_err  output  1  first stop bit sampled low.
- busy  output  1  frame reception in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - data=0, ack=0, check_err=0, frame_err=0, busy=0.
  - state=S_IDLE, all counters 0.
  - Both synchronizer flops reset to 1.
- rx passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Tick chain:
  - clk_count counts 0..CLK_DIV-1, where CLK_DIV = CLK_FREQ/10.
  - On wrap, hns_count counts 0..baud_div.
  - On that wrap, a sample tick is generated and sample_count (3 bits) advances 0..7.
  - Wrap of sample_count marks bit end.
  - All counters are held at 0 in S_IDLE and S_WAIT.
- Bit value = majority of rxs at sample_count 3, 4, 5, taken on sample ticks. The decision is available at sample 5.
- States: S_IDLE, S_START, S_DATA0..S_DATA7, S_CHECK, S_STOP, S_WAIT.
- S_IDLE:
  - rxs==0 → S_START.
  - busy=0; busy=1 in every other state except S_WAIT.
- S_START:
  - Start bit decided 1 (false start, glitch) → S_IDLE; no ack, flags unchanged.
  - Otherwise, at bit end → S_DATA0.
- S_DATAn:
  - At bit end, shift the bit into the shift register.
  - Last data bit per data_type is DATA4/5/6/7 for 11/10/01/00. After it → S_CHECK if check_en, else S_STOP.
- S_CHECK:
  - Expected bit is ~^data (odd), ^data (even), 1 (mark) or 0 (space), computed over the configured width only.
  - Mismatch sets an internal check flag.
  - At bit end → S_STOP.
- S_STOP:
  - At the sample-5 decision, latch the following and pulse ack for exactly one cycle:
    - data = right-justified shift register;
    - check_err = check flag (0 if check_en=0);
    - frame_err = ~stop bit.
  - Then → S_WAIT.
  - Latency: ack rises 1 clk after the sample tick at stop-bit sample 5.
- S_WAIT:
  - Stays until rxs==1, then → S_IDLE.
  - Prevents retrigger on a break (line held low). A break yields exactly one ack with frame_err=1 and data=0.
- data, check_err and frame_err hold until the next ack.
- Configuration inputs must be stable while busy. Changes while busy give undefined data, but the FSM must still return to S_IDLE.
- rst_n mid-frame: immediate return to reset values; no ack for the partial frame.
- baud_div=0 is legal: the fastest rate, with one sample tick per CLK_DIV clocks.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: bit value is the 3-sample majority (samples 3, 4, 5) as described in Behaviour.
- Undefined:
  - Bit value is the single sample at sample_count 4, with the decision made at sample 4.
  - ack in S_STOP occurs one sample tick earlier.
  - No majority logic is generated.

Test Plan:
- Config CLK_FREQ=100, baud_div=9 (125 kbaud, 800 clk/bit), data_type=00, no check, 1 stop. Send 0xA5 → one ack pulse; data=0xA5, check_err=0, frame_err=0, busy low after ack.
- data_type=11, check_en=1, check_type=00 (odd). Send 5-bit 0x13 with correct check bit 0 → data=0x13, check_err=0. Resend with check bit 1 → check_err=1.
- Low pulse of 200 clk on idle rx → no ack; busy returns to 0 after about 1 bit time. Then send 0x3C → data=0x3C.
- Send 0x55 with stop bit forced 0, then hold rx low for 5 bit times → exactly one ack, data=0x55, frame_err=1; no further ack until rx is high and a new start bit is sent.
- Assert rst_n low for 3 clk during S_DATA3 → outputs 0 immediately, no ack. Next clean frame 0x81 → data=0x81.
- Back-to-back frames 0x00 then 0xFF, stop_type=10, with no idle gap beyond the stop bits → two acks, data 0x00 then 0xFF, no errors.
